// File: rtl/udiv64_sched.sv
// udiv64_sched: round-robin scheduler sharing one chunked udiv64 divider; optional macro UDIV64_SCHED_DIV0_BYPASS_EN answers zero-divisor jobs without starting the divider
module udiv64_sched #(
  parameter int          NUM_REQ = 4,
  parameter int          ID_W    = 3,
  parameter logic [15:0] TIMEOUT = 16'd200
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*64-1:0]   req_dividend,
  input  logic [NUM_REQ*64-1:0]   req_divisor,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [63:0]             rsp_quotient,
  output logic [63:0]             rsp_remainder,
  output logic                    rsp_err,
  output logic [31:0]             div_in_loc,
  output logic [31:0]             div_in_val,
  output logic [31:0]             div_ctrl,
  input  logic [31:0]             div_out_loc,
  input  logic [31:0]             div_out_val,
  input  logic [31:0]             div_state,
  output logic                    busy
);
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_START, S_WAIT, S_READ, S_CLEAR, S_RSP} state_t;
  state_t               r_state, w_state;
  logic [15:0]          r_cnt, w_cnt;
  logic [ID_W-1:0]      r_ptr, w_ptr;
  logic [63:0]          r_dvd, w_dvd;
  logic [63:0]          r_dvs, w_dvs;
  logic [NUM_REQ-1:0]   r_req_ready, w_req_ready;
  logic                 r_rsp_valid, w_rsp_valid;
  logic [ID_W-1:0]      r_id, w_id;
  logic [63:0]          r_q, w_q;
  logic [63:0]          r_r, w_r;
  logic                 r_err, w_err;
  logic [31:0]          r_in_loc, w_in_loc;
  logic [31:0]          r_in_val, w_in_val;
  logic [31:0]          r_ctrl, w_ctrl;
  logic                 r_busy, w_busy;
  logic                 w_found;
  logic [ID_W-1:0]      w_gnt;
  logic [63:0]          w_gdvd, w_gdvs;
  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_id        = r_id;
  assign rsp_quotient  = r_q;
  assign rsp_remainder = r_r;
  assign rsp_err       = r_err;
  assign div_in_loc    = r_in_loc;
  assign div_in_val    = r_in_val;
  assign div_ctrl      = r_ctrl;
  assign busy          = r_busy;
  // round-robin pick: nearest valid requester after the pointer wins (descending scan so the closest overwrites last)
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_gdvd  = '0;
    w_gdvs  = '0;
    for (int i = NUM_REQ; i >= 1; i--)
      for (int k = 0; k < NUM_REQ; k++)
        if (req_valid[k] && k == (int'(r_ptr) + i) % NUM_REQ) begin
          w_found = 1'b1;
          w_gnt   = ID_W'(k);
          w_gdvd  = req_dividend[64*k +: 64];
          w_gdvs  = req_divisor[64*k +: 64];
        end
  end
  // next state and next value of every registered output
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_ptr       = r_ptr;
    w_dvd       = r_dvd;
    w_dvs       = r_dvs;
    w_req_ready = '0;
    w_rsp_valid = r_rsp_valid;
    w_id        = r_id;
    w_q         = r_q;
    w_r         = r_r;
    w_err       = r_err;
    w_in_loc    = r_in_loc;
    w_in_val    = r_in_val;
    w_ctrl      = r_ctrl;
    case (r_state)
      S_IDLE: begin
        w_ctrl   = '0;
        w_in_loc = '0;
        w_in_val = '0;
        w_state  = |req_valid ? S_ARB : S_IDLE;
      end
      S_ARB: begin
        w_state = S_IDLE;
        if (w_found) begin
          w_req_ready = NUM_REQ'(1) << w_gnt;
          w_ptr       = w_gnt;
          w_id        = w_gnt;
          w_dvd       = w_gdvd;
          w_dvs       = w_gdvs;
          w_q         = '0;
          w_r         = '0;
          w_err       = 1'b0;
          w_cnt       = '0;
          w_in_loc    = 32'd1;
          w_in_val    = w_gdvd[31:0];
          w_state     = S_LOAD;
`ifdef UDIV64_SCHED_DIV0_BYPASS_EN
          if (w_gdvs == '0) begin
            w_q      = '1;
            w_r      = w_gdvd;
            w_err    = 1'b1;
            w_in_loc = '0;
            w_in_val = '0;
            w_state  = S_RSP;
          end
`endif
        end
      end
      S_LOAD: begin
        w_cnt    = r_cnt + 16'd1;
        w_in_loc = r_in_loc + 32'd1;
        w_in_val = r_cnt == 16'd0 ? r_dvd[63:32] : r_cnt == 16'd1 ? r_dvs[31:0] : r_dvs[63:32];
        if (r_cnt == 16'd3) begin
          w_in_loc = '0;
          w_in_val = '0;
          w_ctrl   = 32'd1;
          w_state  = S_START;
        end
      end
      S_START: begin
        w_cnt   = '0;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        w_cnt = r_cnt + 16'd1;
        if (div_state == 32'd3) begin
          w_cnt    = '0;
          w_in_loc = 32'd4;
          w_state  = S_READ;
        end else if (r_cnt == TIMEOUT) begin
          w_err    = 1'b1;
          w_q      = '0;
          w_r      = '0;
          w_in_loc = '0;
          w_state  = S_CLEAR;
        end
      end
      S_READ: begin
        w_cnt    = r_cnt + 16'd1;
        w_in_loc = r_cnt < 16'd3 ? r_in_loc + 32'd1 : '0;
        if (r_cnt == 16'd1 && div_out_loc == 32'd1) w_q[31:0]  = div_out_val;
        if (r_cnt == 16'd2 && div_out_loc == 32'd2) w_q[63:32] = div_out_val;
        if (r_cnt == 16'd3 && div_out_loc == 32'd3) w_r[31:0]  = div_out_val;
        if (r_cnt == 16'd4 && div_out_loc == 32'd4) w_r[63:32] = div_out_val;
        if (r_cnt == 16'd4) w_state = S_CLEAR;
      end
      S_CLEAR: begin
        w_in_loc = '0;
        w_ctrl   = '0;
        if (r_ctrl == '0 && div_state == '0) w_state = S_RSP;
      end
      S_RSP: begin
        w_rsp_valid = 1'b1;
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = w_state != S_IDLE;
  end
  // register state and outputs; reset drops any job in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= 1'b0;
      r_id        <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_err       <= 1'b0;
      r_in_loc    <= '0;
      r_in_val    <= '0;
      r_ctrl      <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_ptr       <= w_ptr;
      r_dvd       <= w_dvd;
      r_dvs       <= w_dvs;
      r_req_ready <= w_req_ready;
      r_rsp_valid <= w_rsp_valid;
      r_id        <= w_id;
      r_q         <= w_q;
      r_r         <= w_r;
      r_err       <= w_err;
      r_in_loc    <= w_in_loc;
      r_in_val    <= w_in_val;
      r_ctrl      <= w_ctrl;
      r_busy      <= w_busy;
    end
  end
endmodule

// File: tb/tb_udiv64_sched.sv
// tb_udiv64_sched: directed checks of udiv64_sched against a behavioural chunked divider
module tb_udiv64_sched;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [255:0] req_dividend = '0;
  logic [255:0] req_divisor = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [2:0]   rsp_id;
  logic [63:0]  rsp_quotient, rsp_remainder;
  logic         rsp_err;
  logic [31:0]  div_in_loc, div_in_val, div_ctrl;
  logic [31:0]  div_out_loc, div_out_val, div_state;
  logic         busy;
  int           n_pass = 0;
  int           n_total = 0;
  int           cyc = 0;
  int           ctrl_hi = 0;
  int           g_cyc = 0;
  logic [63:0]  m_a, m_b, m_q, m_r;
  int           m_cnt;
  udiv64_sched dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
    .div_in_loc(div_in_loc), .div_in_val(div_in_val), .div_ctrl(div_ctrl),
    .div_out_loc(div_out_loc), .div_out_val(div_out_val), .div_state(div_state),
    .busy(busy)
  );
  always #5 clk = ~clk;
  assign m_q = m_b == 64'd0 ? '1 : m_a / m_b;
  assign m_r = m_b == 64'd0 ? m_a : m_a % m_b;
  // divider: loads chunks while stopped, runs 120 cycles through DIV1/DIV2, reads back one cycle after a location is presented
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_ctrl != 32'd0) ctrl_hi <= ctrl_hi + 1;
    if (reset) begin
      div_state   <= '0;
      div_out_loc <= '0;
      div_out_val <= '0;
      m_cnt       <= 0;
      m_a         <= '0;
      m_b         <= '0;
    end else begin
      if (div_ctrl == 32'd0) begin
        div_state <= '0;
        if (div_in_loc == 32'd1) m_a[31:0]  <= div_in_val;
        if (div_in_loc == 32'd2) m_a[63:32] <= div_in_val;
        if (div_in_loc == 32'd3) m_b[31:0]  <= div_in_val;
        if (div_in_loc == 32'd4) m_b[63:32] <= div_in_val;
      end else if (div_state == 32'd0) begin
        div_state <= 32'd1;
        m_cnt     <= 0;
      end else if (div_state != 32'd3) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == 63) div_state <= 32'd2;
        if (m_cnt == 119) div_state <= 32'd3;
      end
      div_out_loc <= (div_in_loc >= 32'd4 && div_in_loc <= 32'd7) ? div_in_loc - 32'd3 : 32'd0;
      div_out_val <= div_in_loc == 32'd4 ? m_q[31:0] : div_in_loc == 32'd5 ? m_q[63:32] :
                     div_in_loc == 32'd6 ? m_r[31:0] : div_in_loc == 32'd7 ? m_r[63:32] : 32'd0;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic send(input int id, input logic [63:0] a, input logic [63:0] b, input string tag);
    int t;
    t = 0;
    req_dividend[64*id +: 64] = a;
    req_divisor[64*id +: 64]  = b;
    req_valid[id] = 1'b1;
    while (req_ready == 4'd0 && t < 300) begin
      tick();
      t++;
    end
    g_cyc = cyc;
    check({tag, "_grant"}, 64'(req_ready), 64'(4'b1 << id));
    tick();
    req_valid[id] = 1'b0;
    check({tag, "_pulse"}, 64'(req_ready), 64'd0);
  endtask
  task automatic expect_rsp(input int id, input logic [63:0] q, input logic [63:0] r, input logic err, input string tag);
    int t;
    t = 0;
    while (!rsp_valid && t < 300) begin
      tick();
      t++;
    end
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_lat"}, 64'(cyc - g_cyc <= 145), 64'd1);
    check({tag, "_id"}, 64'(rsp_id), 64'(id));
    check({tag, "_q"}, rsp_quotient, q);
    check({tag, "_r"}, rsp_remainder, r);
    check({tag, "_err"}, 64'(rsp_err), 64'(err));
    tick();
    check({tag, "_done"}, 64'(rsp_valid), 64'd0);
  endtask
  logic [63:0] fa [4] = '{64'd1000, 64'd12345, 64'h1_0000_0000, 64'd999};
  logic [63:0] fb [4] = '{64'd10, 64'd100, 64'd3, 64'd1000};
  logic [63:0] fq [4] = '{64'd100, 64'd123, 64'h5555_5555, 64'd0};
  logic [63:0] fr [4] = '{64'd0, 64'd45, 64'd1, 64'd999};
  logic [63:0] s_q, s_r;
  logic [2:0]  s_id;
  logic        s_err, ok;
  int          c0, t;
  initial begin
    repeat (3) tick();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ctrl", 64'(div_ctrl), 64'd0);
    check("rst_loc", 64'(div_in_loc), 64'd0);
    check("rst_q", rsp_quotient, 64'd0);
    reset = 1'b0;
    tick();
    send(2, 64'd100, 64'd7, "single");
    expect_rsp(2, 64'd14, 64'd2, 1'b0, "single");
    send(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, "wide");
    expect_rsp(3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, "wide");
    for (int k = 0; k < 4; k++) begin
      req_dividend[64*k +: 64] = fa[k];
      req_divisor[64*k +: 64]  = fb[k];
    end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      t = 0;
      while (req_ready == 4'd0 && t < 300) begin
        tick();
        t++;
      end
      g_cyc = cyc;
      check("fair_grant", 64'(req_ready), 64'(4'b1 << (k % 4)));
      tick();
      if (k == 4) req_valid = '0;
      expect_rsp(k % 4, fq[k % 4], fr[k % 4], 1'b0, "fair");
    end
    rsp_ready = 1'b0;
    send(1, 64'd77, 64'd5, "bp");
    t = 0;
    while (!rsp_valid && t < 300) begin
      tick();
      t++;
    end
    check("bp_valid", 64'(rsp_valid), 64'd1);
    check("bp_q", rsp_quotient, 64'd15);
    check("bp_r", rsp_remainder, 64'd2);
    check("bp_id", 64'(rsp_id), 64'd1);
    req_dividend[64*3 +: 64] = 64'd50;
    req_divisor[64*3 +: 64]  = 64'd7;
    req_valid[3] = 1'b1;
    s_q = rsp_quotient;
    s_r = rsp_remainder;
    s_id = rsp_id;
    s_err = rsp_err;
    ok = 1'b1;
    repeat (50) begin
      tick();
      if (!rsp_valid || req_ready != 4'd0 || rsp_quotient !== s_q || rsp_remainder !== s_r || rsp_id !== s_id || rsp_err !== s_err) ok = 1'b0;
    end
    check("bp_stable", 64'(ok), 64'd1);
    rsp_ready = 1'b1;
    tick();
    check("bp_accept", 64'(rsp_valid), 64'd0);
    send(3, 64'd50, 64'd7, "after_bp");
    expect_rsp(3, 64'd7, 64'd1, 1'b0, "after_bp");
    c0 = ctrl_hi;
    send(0, 64'd5, 64'd0, "div0");
`ifdef UDIV64_SCHED_DIV0_BYPASS_EN
    check("div0_next_cycle", 64'(rsp_valid), 64'd1);
    expect_rsp(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1, "div0");
    check("div0_no_start", 64'(ctrl_hi), 64'(c0));
`else
    expect_rsp(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b0, "div0");
`endif
    send(2, 64'd100, 64'd7, "midrst");
    repeat (30) tick();
    check("midrst_running", 64'(div_ctrl), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ctrl", 64'(div_ctrl), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd0);
    check("midrst_outs", {rsp_quotient | rsp_remainder}, 64'd0);
    check("midrst_misc", 64'({rsp_valid, rsp_err, rsp_id, div_in_loc, div_in_val}), 64'd0);
    ok = 1'b1;
    repeat (200) begin
      tick();
      if (rsp_valid || busy) ok = 1'b0;
    end
    check("midrst_no_rsp", 64'(ok), 64'd1);
    send(0, 64'd81, 64'd9, "post_rst");
    expect_rsp(0, 64'd9, 64'd0, 1'b0, "post_rst");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
